fft_8_frame_loader: RTL and testbench



---
 rtl/fft_8_frame_loader.sv | 111 +++++++++++
 tb/tb_fft_8_frame_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_8_frame_loader.sv
`default_nettype none
// ============================================================================
// fft_8_frame_loader : ping-pong 8-sample frame assembler feeding the FFT core
// Revision 1.0
// ============================================================================
module fft_8_frame_loader #(
   parameter int DATA_W = 16,
   parameter int N      = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [DATA_W-1:0] s_real,
   input  logic signed [DATA_W-1:0] s_imag,
   input  logic                     s_last,
   input  logic [1:0]               in_shift,
   output logic                     frame_valid,
   input  logic                     frame_ready,
   output logic signed [DATA_W-1:0] frame_real [0:N-1],
   output logic signed [DATA_W-1:0] frame_imag [0:N-1],
   output logic                     frame_err,
   output logic [7:0]               drop_count
);

   localparam int               IDX_W      = $clog2(N);
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);
   localparam logic [7:0]       c_cnt_max  = 8'hFF;

   logic signed [DATA_W-1:0] r_bank_re [0:1][0:N-1];
   logic signed [DATA_W-1:0] r_bank_im [0:1][0:N-1];
   logic [1:0]               r_full;
   logic                     r_wr_sel;
   logic                     r_rd_sel;
   logic [IDX_W-1:0]         r_wr_idx;
   logic [1:0]               r_shift_q;
   logic                     r_frame_err;
   logic [7:0]               r_drop_count;

   logic                     w_accept;
   logic                     w_at_end;
   logic                     w_complete;
   logic                     w_drop;
   logic                     w_consume;
   logic [1:0]               w_shift;
   logic signed [DATA_W-1:0] w_re_sc;
   logic signed [DATA_W-1:0] w_im_sc;
   logic [1:0]               w_full_next;

   assign s_ready     = ~r_full[r_wr_sel];
   assign frame_valid = r_full[r_rd_sel];
   assign frame_err   = r_frame_err;
   assign drop_count  = r_drop_count;

   assign w_accept   = s_valid && s_ready;
   assign w_at_end   = (r_wr_idx == c_last_idx);
   assign w_complete = w_accept && w_at_end && s_last;
   // Short frame (last too early) and long frame (no last at the end) both discard.
   assign w_drop     = w_accept && (w_at_end != s_last);
   assign w_consume  = frame_valid && frame_ready;

   assign w_shift = (r_wr_idx == '0) ? in_shift : r_shift_q;
   assign w_re_sc = s_real >>> w_shift;
   assign w_im_sc = s_imag >>> w_shift;

   // Completion and consumption always target different banks.
   always_comb begin
      w_full_next = r_full;
      if (w_complete) w_full_next[r_wr_sel] = 1'b1;
      if (w_consume)  w_full_next[r_rd_sel] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
               r_bank_re[b][i] <= '0;
               r_bank_im[b][i] <= '0;
            end
         end
         r_full       <= 2'b00;
         r_wr_sel     <= 1'b0;
         r_rd_sel     <= 1'b0;
         r_wr_idx     <= '0;
         r_shift_q    <= 2'd0;
         r_frame_err  <= 1'b0;
         r_drop_count <= 8'd0;
      end else begin
         if (w_accept) begin
            r_bank_re[r_wr_sel][r_wr_idx] <= w_re_sc;
            r_bank_im[r_wr_sel][r_wr_idx] <= w_im_sc;
            if (r_wr_idx == '0) r_shift_q <= in_shift;
            if (w_complete || w_drop) r_wr_idx <= '0;
            else                      r_wr_idx <= r_wr_idx + 1'b1;
         end
         if (w_complete) r_wr_sel <= ~r_wr_sel;
         if (w_consume)  r_rd_sel <= ~r_rd_sel;
         r_full      <= w_full_next;
         r_frame_err <= w_drop;
         if (w_drop && (r_drop_count != c_cnt_max))
            r_drop_count <= r_drop_count + 8'd1;
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign frame_real[gi] = r_bank_re[r_rd_sel][gi];
      assign frame_imag[gi] = r_bank_im[r_rd_sel][gi];
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_8_frame_loader.sv
`default_nettype none
// ============================================================================
// tb_fft_8_frame_loader : randomized scoreboard bench for fft_8_frame_loader
// Revision 1.0
// ============================================================================
module tb_fft_8_frame_loader;

   localparam int DW = 16;
   localparam int NS = 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 s_valid;
   logic                 s_ready;
   logic signed [DW-1:0] s_real;
   logic signed [DW-1:0] s_imag;
   logic                 s_last;
   logic [1:0]           in_shift;
   logic                 frame_valid;
   logic                 frame_ready;
   logic signed [DW-1:0] frame_real [0:NS-1];
   logic signed [DW-1:0] frame_imag [0:NS-1];
   logic                 frame_err;
   logic [7:0]           drop_count;

   always #5 clk = ~clk;

   fft_8_frame_loader #(.DATA_W(DW), .N(NS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_real      (s_real),
      .s_imag      (s_imag),
      .s_last      (s_last),
      .in_shift    (in_shift),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_real  (frame_real),
      .frame_imag  (frame_imag),
      .frame_err   (frame_err),
      .drop_count  (drop_count)
   );

   typedef struct {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
      logic                 last;
      logic [1:0]           sh;
      int                   gap;
   } stim_t;

   typedef struct packed {
      logic [NS-1:0][DW-1:0] re;
      logic [NS-1:0][DW-1:0] im;
   } frame_t;

   typedef struct {
      int cyc;
      int cnt;
   } err_t;

   stim_t  stim_q [$];
   frame_t exp_q  [$];
   err_t   err_q  [$];
   logic signed [DW-1:0] buf_re [$];
   logic signed [DW-1:0] buf_im [$];
   logic [1:0] fshift;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int n_done = 0, n_done_vis = 0, n_cons = 0, drops = 0;
   bit mon_en = 1'b0;
   bit busy   = 1'b0;
   int rdy_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: frames are runs of accepted samples; a run is emitted only
   // if its 8th sample carries last, otherwise the run is dropped.
   task automatic model_accept(stim_t s);
      logic signed [DW-1:0] vr, vi;
      frame_t nf;
      if (buf_re.size() == 0) fshift = s.sh;
      vr = s.re >>> fshift;
      vi = s.im >>> fshift;
      buf_re.push_back(vr);
      buf_im.push_back(vi);
      if (buf_re.size() == NS || s.last) begin
         if (buf_re.size() == NS && s.last) begin
            for (int i = 0; i < NS; i++) begin
               nf.re[i] = buf_re[i];
               nf.im[i] = buf_im[i];
            end
            exp_q.push_back(nf);
            n_done++;
         end else begin
            drops = (drops < 255) ? drops + 1 : 255;
            err_q.push_back('{cyc + 1, drops});
         end
         buf_re.delete();
         buf_im.delete();
      end
   endtask

   task automatic push_s(int re, int im, bit last, int sh, int gap);
      stim_t s;
      s.re = DW'(re); s.im = DW'(im); s.last = last; s.sh = 2'(sh); s.gap = gap;
      stim_q.push_back(s);
   endtask

   // Driver: holds each sample until accepted; drives junk while idle.
   initial begin
      stim_t cur;
      bit    have = 1'b0;
      int    gap  = 0;
      s_valid = 1'b0; s_real = '0; s_imag = '0; s_last = 1'b0; in_shift = 2'd0;
      forever begin
         @(negedge clk);
         n_done_vis = n_done;
         if (!rst_n) begin
            have = 1'b0;
            s_valid = 1'b0;
         end else begin
            if (!have && stim_q.size() > 0) begin
               cur = stim_q.pop_front();
               have = 1'b1;
               gap = cur.gap;
            end
            if (have && gap > 0) begin
               gap--;
               s_valid = 1'b0;
               s_real = DW'($urandom); s_imag = DW'($urandom);
               s_last = 1'($urandom); in_shift = 2'($urandom);
            end else if (have) begin
               s_valid = 1'b1;
               s_real = cur.re; s_imag = cur.im; s_last = cur.last; in_shift = cur.sh;
               if (s_ready) begin
                  model_accept(cur);
                  have = 1'b0;
               end
            end else begin
               s_valid = 1'b0;
               s_real = DW'($urandom); s_imag = DW'($urandom);
               s_last = 1'($urandom); in_shift = 2'($urandom);
            end
         end
         busy = have;
      end
   end

   initial begin
      frame_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       frame_ready = 1'b0;
            1:       frame_ready = 1'b1;
            default: frame_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor / scoreboard
   initial begin
      frame_t f;
      err_t   e;
      bit     ok;
      int     bad;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && rst_n) begin
            check("s_ready", s_ready, (n_done_vis - n_cons) < 2);
            check("frame_valid", frame_valid, (n_done_vis - n_cons) > 0);
            if (err_q.size() > 0 && err_q[0].cyc < cyc) begin
               e = err_q.pop_front();
               tests++; fails++;
               $display("FAIL frame_err_missing: got 0 expected pulse at cycle %0d", e.cyc);
            end
            if (frame_err) begin
               if (err_q.size() == 0 || err_q[0].cyc != cyc) begin
                  tests++; fails++;
                  $display("FAIL frame_err_unexpected: got 1 expected 0 (cycle %0d)", cyc);
               end else begin
                  e = err_q.pop_front();
                  check("drop_count", drop_count, e.cnt);
               end
            end
            if (frame_valid && frame_ready) begin
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL frame_unexpected: got frame expected none (cycle %0d)", cyc);
               end else begin
                  f = exp_q.pop_front();
                  ok = 1'b1; bad = 0;
                  for (int i = 0; i < NS; i++) begin
                     if (ok && (frame_real[i] !== f.re[i] || frame_imag[i] !== f.im[i])) begin
                        ok = 1'b0; bad = i;
                     end
                  end
                  tests++;
                  if (!ok) begin
                     fails++;
                     $display("FAIL frame_data elem %0d: got re=%0d im=%0d expected re=%0d im=%0d",
                              bad, frame_real[bad], frame_imag[bad],
                              $signed(f.re[bad]), $signed(f.im[bad]));
                  end
               end
               n_cons++;
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_input(int maxc, string name);
      int n = 0;
      while ((stim_q.size() > 0 || busy) && n < maxc) begin
         @(posedge clk); n++;
      end
      #1;
      tests++;
      if (n >= maxc) begin
         fails++;
         $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, n, maxc);
      end
   endtask

   task automatic wait_all(int maxc, string name);
      int n = 0;
      while ((stim_q.size() > 0 || busy || exp_q.size() > 0 || err_q.size() > 0) && n < maxc) begin
         @(posedge clk); n++;
      end
      #1;
      tests++;
      if (n >= maxc) begin
         fails++;
         $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, n, maxc);
      end
   endtask

   task automatic gen_frames(int nf);
      int kind, len;
      for (int f = 0; f < nf; f++) begin
         kind = $urandom_range(0, 9);
         len  = (kind == 8) ? $urandom_range(1, 7) : NS;
         for (int k = 0; k < len; k++)
            push_s($urandom, $urandom, (k == len - 1) && (kind != 9), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      tick(3);
      check("rst_s_ready", s_ready, 1);
      check("rst_frame_valid", frame_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_drop_count", drop_count, 0);
      for (int i = 0; i < NS; i++) begin
         check("rst_frame_real", frame_real[i], 0);
         check("rst_frame_imag", frame_imag[i], 0);
      end
      rst_n = 1'b1;
      mon_en = 1'b1;

      // single frame held until consumed
      rdy_mode = 0;
      for (int k = 0; k < NS; k++) push_s(1000 * k, -k, k == NS - 1, 0, 0);
      wait_input(200, "single_in");
      tick(5);
      check("single_hold_valid", frame_valid, 1);
      check("single_real3", frame_real[3], 3000);
      check("single_imag7", frame_imag[7], -7);
      rdy_mode = 1;
      wait_all(200, "single");

      // streaming
      rdy_mode = 1;
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < NS; k++) push_s($urandom, $urandom, k == NS - 1, $urandom_range(0, 3), 0);
      wait_all(400, "stream");

      // back-pressure
      rdy_mode = 0;
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < NS; k++) push_s($urandom, $urandom, k == NS - 1, 0, 0);
      tick(30);
      check("bp_s_ready_low", s_ready, 0);
      check("bp_pending_samples", stim_q.size() + int'(busy), 8);
      rdy_mode = 1;
      tick(1);
      rdy_mode = 0;
      tick(3);
      check("bp_s_ready_back", s_ready, 1);
      rdy_mode = 2;
      wait_all(400, "bp");

      // framing errors
      for (int k = 0; k < 5; k++) push_s(k, k, k == 4, 0, 0);
      for (int k = 0; k < NS; k++) push_s(k, k, 0, 0, 0);
      for (int k = 0; k < NS; k++) push_s(500 + k, -500 - k, k == NS - 1, 1, 0);
      wait_all(400, "framing");
      check("framing_drop_count", drop_count, 2);

      // scaling with in_shift changing mid-frame
      rdy_mode = 0;
      for (int k = 0; k < NS; k++) push_s(-32768, 7, k == NS - 1, (k == 0) ? 2 : 0, 0);
      wait_input(200, "scale_in");
      tick(2);
      check("scale_real0", frame_real[0], -8192);
      check("scale_imag5", frame_imag[5], 1);
      rdy_mode = 1;
      wait_all(200, "scale");

      // randomized traffic
      rdy_mode = 2;
      gen_frames(40);
      wait_all(5000, "random");

      // drop counter saturation
      for (int k = 0; k < 260; k++) push_s(k, k, 1, 0, 0);
      wait_all(2000, "saturate");
      check("sat_drop_count", drop_count, 255);

      // asynchronous reset with a frame pending and a partial frame
      rdy_mode = 0;
      for (int k = 0; k < NS + 3; k++) push_s($urandom, $urandom, k == NS - 1, 0, 0);
      wait_input(200, "arst_in");
      tick(2);
      check("arst_pre_valid", frame_valid, 1);
      #3;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_frame_valid", frame_valid, 0);
      check("arst_s_ready", s_ready, 1);
      check("arst_drop_count", drop_count, 0);
      check("arst_frame_real0", frame_real[0], 0);
      exp_q.delete(); err_q.delete(); buf_re.delete(); buf_im.delete();
      n_done = 0; n_done_vis = 0; n_cons = 0; drops = 0;
      tick(1);
      rst_n = 1'b1;
      mon_en = 1'b1;
      for (int k = 0; k < NS; k++) push_s(-100 * k, 100 * k, k == NS - 1, 1, 0);
      rdy_mode = 1;
      wait_all(200, "arst_clean");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
